// File: rtl/serial_feeder_pkg.sv
// Shared types and sizes for the serial_feeder instruction serialiser.
package serial_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OPC  = 2'd1,
    ST_OPR  = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned FRAME_W = 2 + MAX_LEN;

  function automatic logic [4:0] clamp_len(input logic [4:0] len);
    return (len > 5'(MAX_LEN)) ? 5'(MAX_LEN) : len;
  endfunction

endpackage

// File: rtl/serial_feeder_bit_timer.sv
// Per-bit phase timer: HALF_PERIOD low cycles then HALF_PERIOD high cycles.
module bit_timer
  import serial_feeder_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  input  logic i_restart,
  output logic o_phase_hi,
  output logic o_bit_end
);

  localparam logic [7:0] H_LAST = 8'(HALF_PERIOD - 1);

  logic [7:0] r_cnt;
  logic       r_hi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_hi  <= 1'b0;
    end else if (!i_run || i_restart) begin
      r_cnt <= '0;
      r_hi  <= 1'b0;
    end else if (r_cnt == H_LAST) begin
      r_cnt <= '0;
      r_hi  <= ~r_hi;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // The high flag is a flop, so the serial clock derived from it is glitch-free.
  assign o_phase_hi = r_hi;
  assign o_bit_end  = r_hi && (r_cnt == H_LAST);

endmodule

// File: rtl/serial_feeder.sv
// Parallel frame to ser_clk/ser_data serialiser with idle gap between frames.
// Optional one-entry prefetch buffer: define SERIAL_FEEDER_PREFETCH_EN.
module serial_feeder
  import serial_feeder_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 2,
  parameter int unsigned GAP         = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_opcode,
  input  logic [MAX_LEN-1:0]  in_operand,
  input  logic [4:0]          in_len,
  output logic                ser_clk,
  output logic                ser_data,
  output logic                busy,
  output logic                done
);

  localparam logic [7:0] GAP_LAST = 8'(GAP - 1);

  state_t               r_state, w_next;
  logic [FRAME_W-1:0]   r_shift;
  logic [4:0]           r_len, r_bits;
  logic [7:0]           r_gap;
  logic                 w_load, w_shift, w_xfer, w_have, w_sending;
  logic                 w_phase_hi, w_bit_end;
  logic [1:0]           w_src_op;
  logic [MAX_LEN-1:0]   w_src_opd;
  logic [4:0]           w_src_len;

  assign w_xfer = in_valid & in_ready;

`ifdef SERIAL_FEEDER_PREFETCH_EN
  logic                 r_buf_valid;
  logic [1:0]           r_buf_op;
  logic [MAX_LEN-1:0]   r_buf_opd;
  logic [4:0]           r_buf_len;

  assign in_ready  = !r_buf_valid;
  assign w_have    = r_buf_valid | w_xfer;
  assign w_src_op  = r_buf_valid ? r_buf_op  : in_opcode;
  assign w_src_opd = r_buf_valid ? r_buf_opd : in_operand;
  assign w_src_len = r_buf_valid ? r_buf_len : in_len;

  // A transfer coinciding with a load bypasses the buffer; otherwise it is parked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf_valid <= 1'b0;
      r_buf_op    <= '0;
      r_buf_opd   <= '0;
      r_buf_len   <= '0;
    end else if (w_load && r_buf_valid) begin
      r_buf_valid <= 1'b0;
    end else if (w_xfer && !w_load) begin
      r_buf_valid <= 1'b1;
      r_buf_op    <= in_opcode;
      r_buf_opd   <= in_operand;
      r_buf_len   <= in_len;
    end
  end
`else
  assign in_ready  = (r_state == ST_IDLE);
  assign w_have    = w_xfer;
  assign w_src_op  = in_opcode;
  assign w_src_opd = in_operand;
  assign w_src_len = in_len;
`endif

  assign w_sending = (r_state == ST_OPC) || (r_state == ST_OPR);

  bit_timer #(.HALF_PERIOD(HALF_PERIOD)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_run      (w_sending),
    .i_restart  (w_load),
    .o_phase_hi (w_phase_hi),
    .o_bit_end  (w_bit_end)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_shift = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_have) begin
          w_next = ST_OPC;
          w_load = 1'b1;
        end
      end
      ST_OPC: begin
        if (w_bit_end) begin
          w_shift = 1'b1;
          if (r_bits == '0) w_next = (r_len == '0) ? ST_GAP : ST_OPR;
        end
      end
      ST_OPR: begin
        if (w_bit_end) begin
          w_shift = 1'b1;
          if (r_bits == '0) w_next = ST_GAP;
        end
      end
      ST_GAP: begin
        if (r_gap == GAP_LAST) begin
          if (w_have) begin
            w_next = ST_OPC;
            w_load = 1'b1;
          end else begin
            w_next = ST_IDLE;
          end
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // r_bits counts remaining bits of the current section, reloaded for the operand.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_len   <= '0;
      r_bits  <= '0;
      r_gap   <= '0;
    end else if (w_load) begin
      r_shift <= {w_src_op, w_src_opd};
      r_len   <= clamp_len(w_src_len);
      r_bits  <= 5'd1;
      r_gap   <= '0;
    end else begin
      if (w_shift) begin
        r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
        if (r_bits != '0)            r_bits <= r_bits - 5'd1;
        else if (r_state == ST_OPC)  r_bits <= r_len - 5'd1;
      end
      if (r_state == ST_GAP) r_gap <= r_gap + 8'd1;
      else                   r_gap <= '0;
    end
  end

  assign ser_clk  = w_phase_hi;
  assign ser_data = w_sending & r_shift[FRAME_W-1];
  assign busy     = (r_state != ST_IDLE);
  assign done     = (r_state == ST_GAP) && (r_gap == '0);

endmodule

// File: tb/tb_serial_feeder.sv
// Directed self-checking bench for serial_feeder (H=2, GAP=4).
module tb_serial_feeder;

  localparam int H = 2;
  localparam int G = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_opcode;
  logic [15:0] in_operand;
  logic [4:0]  in_len;
  logic        ser_clk, ser_data, busy, done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int stab_err = 0;
  int rise_at[$];
  int rise_val[$];
  int done_at[$];
  logic prev_clk  = 1'b0;
  logic prev_data = 1'b0;

  serial_feeder #(.HALF_PERIOD(H), .GAP(G)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_operand (in_operand),
    .in_len     (in_len),
    .ser_clk    (ser_clk),
    .ser_data   (ser_data),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ser_clk && !prev_clk) begin
      rise_at.push_back(cyc);
      rise_val.push_back(int'(ser_data));
    end
    if (ser_clk && prev_clk && (ser_data != prev_data)) stab_err++;
    if (done) done_at.push_back(cyc);
    prev_clk  = ser_clk;
    prev_data = ser_data;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [15:0] opd, input logic [4:0] len,
                      output int t0);
    int n = 0;
    @(negedge clk);
    in_opcode = op; in_operand = opd; in_len = len; in_valid = 1'b1;
    while (!in_ready && n < 500) begin @(negedge clk); n++; end
    if (!in_ready) check("send_timeout", 32'd0, 32'd1);
    t0 = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    check("busy_after_xfer", 32'(busy), 32'd1);
`ifndef SERIAL_FEEDER_PREFETCH_EN
    check("ready_in_flight", 32'(in_ready), 32'd0);
`endif
  endtask

  task automatic wait_idle(output int t);
    int n = 0;
    while (busy && n < 1000) begin @(negedge clk); n++; end
    if (busy) check("idle_timeout", 32'd0, 32'd1);
    t = cyc;
  endtask

  function automatic logic [31:0] bits_from(input int b, input int cnt);
    logic [31:0] v = '0;
    for (int i = 0; i < cnt; i++) v = {v[30:0], rise_val[b + i][0]};
    return v;
  endfunction

  task automatic frame_check(input string nm, input int b_rise, input int b_done,
                             input int t0, input int t_idle, input int n,
                             input logic [31:0] exp_bits);
    check({nm, "_rises"}, 32'(rise_at.size() - b_rise), 32'(n));
    if (rise_at.size() - b_rise == n) begin
      check({nm, "_bits"}, bits_from(b_rise, n), exp_bits);
      check({nm, "_first_rise"}, 32'(rise_at[b_rise]), 32'(t0 + H + 1));
    end
    check({nm, "_dones"}, 32'(done_at.size() - b_done), 32'd1);
    if (done_at.size() - b_done == 1)
      check({nm, "_done_cyc"}, 32'(done_at[b_done]), 32'(t0 + 2*H*n + 1));
    check({nm, "_idle_cyc"}, 32'(t_idle), 32'(t0 + 2*H*n + G + 1));
    check({nm, "_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int t0, t1, ti, br, bd, n;
    rst = 1'b1; in_valid = 1'b0; in_opcode = '0; in_operand = '0; in_len = '0;
    repeat (3) @(negedge clk);
    check("rst_ser_clk",  32'(ser_clk),  32'd0);
    check("rst_ser_data", 32'(ser_data), 32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_done",     32'(done),     32'd0);
    check("rst_ready",    32'(in_ready), 32'd1);
    rst = 1'b0;

    // Opcode 10, no operand: done at k+9, idle/ready at k+13.
    br = rise_at.size(); bd = done_at.size();
    send(2'b10, 16'h0000, 5'd0, t0);
    wait_idle(ti);
    frame_check("f1", br, bd, t0, ti, 2, 32'h2);
    if (done_at.size() - bd == 1) check("f1_done_k9", 32'(done_at[bd] - t0), 32'd9);
    check("f1_ready_k13", 32'(ti - t0), 32'd13);

    // Opcode 01 + full 16-bit operand.
    br = rise_at.size(); bd = done_at.size();
    send(2'b01, 16'hA5C3, 5'd16, t0);
    wait_idle(ti);
    frame_check("f2", br, bd, t0, ti, 18, 32'h1A5C3);

    // len 20 clamps to 16.
    br = rise_at.size(); bd = done_at.size();
    send(2'b11, 16'hFFFF, 5'd20, t0);
    wait_idle(ti);
    frame_check("f3", br, bd, t0, ti, 18, 32'h3FFFF);

`ifndef SERIAL_FEEDER_PREFETCH_EN
    // in_valid held high while not ready: exactly one capture.
    br = rise_at.size(); bd = done_at.size();
    @(negedge clk);
    in_opcode = 2'b00; in_operand = 16'hE000; in_len = 5'd3; in_valid = 1'b1;
    t0 = cyc;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 500) begin @(negedge clk); n++; end
    in_valid = 1'b0;
    check("hold_ready_cyc", 32'(cyc - t0), 32'(2*H*5 + G + 1));
    repeat (30) @(negedge clk);
    check("hold_rises", 32'(rise_at.size() - br), 32'd5);
    check("hold_bits",  bits_from(br, 5), 32'h07);
    check("hold_dones", 32'(done_at.size() - bd), 32'd1);
    check("hold_busy",  32'(busy), 32'd0);
`endif

    // Reset during operand bit 7 (frame bit 9), in its high phase.
    br = rise_at.size(); bd = done_at.size();
    send(2'b10, 16'h0F0F, 5'd16, t0);
    n = 0;
    while (cyc != t0 + 39 && n < 200) begin @(negedge clk); n++; end
    check("mid_pre_high", 32'(ser_clk), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("mid_clk_async", 32'(ser_clk), 32'd0);
    check("mid_busy",      32'(busy),    32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check("mid_rises", 32'(rise_at.size() - br), 32'd10);
    check("mid_bits",  bits_from(br, 10), 32'h20F);
    check("mid_dones", 32'(done_at.size() - bd), 32'd0);
    check("mid_ready", 32'(in_ready), 32'd1);

    br = rise_at.size(); bd = done_at.size();
    send(2'b01, 16'hB000, 5'd4, t0);
    wait_idle(ti);
    frame_check("post", br, bd, t0, ti, 6, 32'h1B);

`ifdef SERIAL_FEEDER_PREFETCH_EN
    // Second frame buffered during the first's operand phase; no IDLE between them.
    br = rise_at.size(); bd = done_at.size();
    send(2'b10, 16'hF000, 5'd4, t0);
    n = 0;
    while (rise_at.size() - br < 3 && n < 200) begin @(negedge clk); n++; end
    send(2'b01, 16'h0000, 5'd4, t1);
    wait_idle(ti);
    check("pf_rises", 32'(rise_at.size() - br), 32'd12);
    if (rise_at.size() - br == 12) begin
      check("pf_bits",    bits_from(br, 12), 32'hBD0);
      check("pf_spacing", 32'(rise_at[br + 6] - rise_at[br]), 32'(2*H*6 + G));
    end
    check("pf_dones", 32'(done_at.size() - bd), 32'd2);
`endif

    check("stable_high", 32'(stab_err), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
